// File: rtl/lfsr_range_rng.sv
// lfsr_range_rng: Fibonacci LFSR pseudo-random source with a bounded-rejection
// range sampler that returns a uniform value in [lo, hi].
//
// Parameters:
//   WIDTH     LFSR width (8, 16, 24 or 32)
//   OUT_W     width of lo/hi/rnd, <= WIDTH
//   MAX_TRIES maximum candidate evaluations per draw, >= 1
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   seed, load  synchronous seed load (zero seed stores 1), highest priority
//   en          free-run step enable while idle
//   req, lo, hi draw request and inclusive range, captured in IDLE
//   busy        high while a draw is in progress (DRAW and DONE)
//   valid       one-cycle result strobe qualifying rnd and err
//   rnd         drawn value, held between draws
//   err         range error (captured lo > hi), valid with the strobe
//   raw         current LFSR state
module lfsr_range_rng #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             en,
  input  logic             req,
  input  logic [OUT_W-1:0] lo,
  input  logic [OUT_W-1:0] hi,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rnd,
  output logic             err,
  output logic [WIDTH-1:0] raw
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic             fb;
  logic [OUT_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [OUT_W-1:0] span, mask, cand, rnd_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             valid_d, busy_d, err_d;
  logic             last_try;

  // Feedback taps per supported width
  if (WIDTH == 8) begin : g_taps8
    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end else if (WIDTH == 16) begin : g_taps16
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end else if (WIDTH == 24) begin : g_taps24
    assign fb = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
  end else begin : g_taps32
    assign fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
  end

  assign lfsr_step = {lfsr_q[WIDTH-2:0], fb};
  assign raw       = lfsr_q;

  // Range span and the smallest all-ones mask covering it (bit smear of span)
  always_comb begin
    span = hi_q - lo_q;
    mask = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      mask = mask | (span >> i);
    end
    cand = lfsr_q[OUT_W-1:0] & mask;
  end

  // The evaluation in progress is the final permitted one
  assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    tries_d = tries_q;
    rnd_d   = rnd;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) lfsr_d = lfsr_step;
        if (req) begin
          lo_d    = lo;
          hi_d    = hi;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        lfsr_d  = lfsr_step;
        tries_d = tries_q + TRY_W'(1);
        if (lo_q > hi_q) begin
          rnd_d   = lo_q;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cand <= span) begin
          rnd_d   = lo_q + cand;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (last_try) begin
          // mask < 2*span, so cand>>1 never exceeds span
          rnd_d   = lo_q + (cand >> 1);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Seed load wins over any step; zero would lock the LFSR
    if (load) lfsr_d = (seed == '0) ? WIDTH'(1) : seed;

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= WIDTH'(1);
      lo_q    <= '0;
      hi_q    <= '0;
      tries_q <= '0;
      rnd     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      tries_q <= tries_d;
      rnd     <= rnd_d;
      valid   <= valid_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Testbench for lfsr_range_rng: three instances (8-bit/16 tries, 8-bit/2 tries,
// 16-bit/16 tries) share stimulus; a transaction-level model predicts draws.
module tb_lfsr_range_rng;

  logic        clk = 1'b0;
  logic        rst_n, load, en, req;
  logic [7:0]  seed8, lo, hi;
  logic [15:0] seed16;

  logic        busy_a, valid_a, err_a, busy_b, valid_b, err_b, busy_c, valid_c, err_c;
  logic [7:0]  rnd_a, rnd_b, rnd_c, raw_a, raw_b;
  logic [15:0] raw_c;

  int checks = 0;
  int failures = 0;

  logic [31:0] m [3];
  int wd [3] = '{8, 8, 16};
  int mt [3] = '{16, 2, 16};

  int vcyc [3];
  int vrnd [3];
  int verr [3];
  int vcnt [3];

  always #5 clk = ~clk;

  lfsr_range_rng #(.WIDTH(8), .OUT_W(8), .MAX_TRIES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed(seed8), .load(load), .en(en), .req(req),
    .lo(lo), .hi(hi), .busy(busy_a), .valid(valid_a), .rnd(rnd_a), .err(err_a), .raw(raw_a));

  lfsr_range_rng #(.WIDTH(8), .OUT_W(8), .MAX_TRIES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed(seed8), .load(load), .en(en), .req(req),
    .lo(lo), .hi(hi), .busy(busy_b), .valid(valid_b), .rnd(rnd_b), .err(err_b), .raw(raw_b));

  lfsr_range_rng #(.WIDTH(16), .OUT_W(8), .MAX_TRIES(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .seed(seed16), .load(load), .en(en), .req(req),
    .lo(lo), .hi(hi), .busy(busy_c), .valid(valid_c), .rnd(rnd_c), .err(err_c), .raw(raw_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR step from the tap list of the given width
  function automatic logic [31:0] mstep(input logic [31:0] s, input int w);
    int taps [4];
    logic fb;
    case (w)
      8:       taps = '{7, 5, 4, 3};
      16:      taps = '{15, 13, 12, 10};
      24:      taps = '{23, 22, 21, 16};
      default: taps = '{31, 21, 1, 0};
    endcase
    fb = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]];
    if (w == 32) return (s << 1) | 32'(fb);
    return ((s << 1) | 32'(fb)) & ((32'd1 << w) - 32'd1);
  endfunction

  // Whole-draw prediction: evaluation count, result, error and final LFSR state
  task automatic predict(input logic [31:0] s0, input int w, input int maxt,
                         input int lo_i, input int hi_i, input int load_after,
                         input logic [31:0] load_val, output int k, output int r,
                         output int e, output logic [31:0] s_end);
    logic [31:0] s, nxt;
    int d, mask, cand;
    s = s0;
    e = 0;
    k = 0;
    r = 0;
    s_end = s0;
    if (lo_i > hi_i) begin
      k = 1; r = lo_i; e = 1;
      s_end = (load_after == 1) ? load_val : mstep(s, w);
      return;
    end
    d = hi_i - lo_i;
    mask = 0;
    while (mask < d) mask = mask * 2 + 1;
    for (int i = 1; i <= maxt; i++) begin
      cand = int'(s[7:0]) & mask;
      nxt = (i == load_after) ? load_val : mstep(s, w);
      if (cand <= d) begin
        k = i; r = lo_i + cand; s_end = nxt;
        return;
      end
      if (i == maxt) begin
        k = i; r = lo_i + (cand >> 1); s_end = nxt;
        return;
      end
      s = nxt;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; load = 1'b0; en = 1'b0; req = 1'b0;
    seed8 = '0; seed16 = '0; lo = '0; hi = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    foreach (m[i]) m[i] = 32'd1;
  endtask

  task automatic do_load(input logic [7:0] s8, input logic [15:0] s16);
    load = 1'b1; seed8 = s8; seed16 = s16;
    tick();
    load = 1'b0;
    m[0] = (s8 == 8'd0) ? 32'd1 : 32'(s8);
    m[1] = m[0];
    m[2] = (s16 == 16'd0) ? 32'd1 : 32'(s16);
  endtask

  // Issue one request and record every instance's first strobe over a fixed window
  task automatic do_draw(input logic [7:0] l, input logic [7:0] h, input int hold,
                         input bit load_mid, input logic [7:0] ls8, input logic [15:0] ls16);
    lo = l; hi = h; req = 1'b1; en = 1'b0;
    tick();
    foreach (vcnt[i]) begin vcnt[i] = 0; vcyc[i] = -1; vrnd[i] = 0; verr[i] = 0; end
    for (int c = 1; c <= 24; c++) begin
      req = (c < hold);
      load = load_mid && (c == 1);
      seed8 = ls8; seed16 = ls16;
      lo = 8'($urandom); hi = 8'($urandom);
      if (valid_a) begin vcnt[0]++; if (vcyc[0] < 0) begin vcyc[0] = c; vrnd[0] = int'(rnd_a); verr[0] = int'(err_a); end end
      if (valid_b) begin vcnt[1]++; if (vcyc[1] < 0) begin vcyc[1] = c; vrnd[1] = int'(rnd_b); verr[1] = int'(err_b); end end
      if (valid_c) begin vcnt[2]++; if (vcyc[2] < 0) begin vcyc[2] = c; vrnd[2] = int'(rnd_c); verr[2] = int'(err_c); end end
      tick();
    end
    load = 1'b0; req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({valid_a, busy_a, err_a, rnd_a, raw_a} !== {3'b000, 8'h00, 8'h01}) begin
      failures++; $display("FAIL reset_a: got %h expected %h", {valid_a, busy_a, err_a, rnd_a, raw_a}, {3'b000, 8'h00, 8'h01});
    end
    checks++;
    if ({valid_c, busy_c, err_c, rnd_c, raw_c} !== {3'b000, 8'h00, 16'h0001}) begin
      failures++; $display("FAIL reset_c: got %h expected %h", {valid_c, busy_c, err_c, rnd_c, raw_c}, {3'b000, 8'h00, 16'h0001});
    end
  endtask

  task automatic test_sequence();
    logic [7:0] tbl [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (raw_a !== tbl[i]) begin failures++; $display("FAIL seq8[%0d]: got %h expected %h", i, raw_a, tbl[i]); end
      checks++;
      if (32'(raw_c) !== m[2]) begin failures++; $display("FAIL seq16[%0d]: got %h expected %h", i, raw_c, m[2]); end
      m[2] = mstep(m[2], 16);
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_period();
    int zero_seen = 0;
    int first_ret = 0;
    apply_reset();
    en = 1'b1;
    for (int s = 1; s <= 300; s++) begin
      tick();
      if (raw_a == 8'h00) zero_seen++;
      if (raw_a == 8'h01 && first_ret == 0) first_ret = s;
    end
    en = 1'b0;
    checks++;
    if (first_ret != 255) begin failures++; $display("FAIL period: got %0d expected 255", first_ret); end
    checks++;
    if (zero_seen != 0) begin failures++; $display("FAIL zero_state: got %0d expected 0", zero_seen); end
  endtask

  task automatic test_load();
    apply_reset();
    do_load(8'h00, 16'h0000);
    checks++;
    if ({raw_a, raw_c} !== {8'h01, 16'h0001}) begin failures++; $display("FAIL load_zero: got %h expected 010001", {raw_a, raw_c}); end
    do_load(8'h47, 16'hBEEF);
    checks++;
    if ({raw_a, raw_c} !== {8'h47, 16'hBEEF}) begin failures++; $display("FAIL load_seed: got %h expected 47beef", {raw_a, raw_c}); end
  endtask

  task automatic test_immediate();
    apply_reset();
    do_draw(8'd10, 8'd13, 1, 1'b0, 8'h00, 16'h0000);
    checks++;
    if ({vcyc[0], vrnd[0], verr[0], vcnt[0]} !== {32'd2, 32'd11, 32'd0, 32'd1}) begin
      failures++; $display("FAIL immediate: got cyc=%0d rnd=%0d err=%0d n=%0d expected cyc=2 rnd=11 err=0 n=1", vcyc[0], vrnd[0], verr[0], vcnt[0]);
    end
  endtask

  task automatic test_reject();
    apply_reset();
    do_load(8'h47, 16'h0047);
    do_draw(8'd0, 8'd4, 1, 1'b0, 8'h00, 16'h0000);
    checks++;
    if ({vcyc[0], vrnd[0], verr[0], vcnt[0]} !== {32'd4, 32'd4, 32'd0, 32'd1}) begin
      failures++; $display("FAIL reject_accept: got cyc=%0d rnd=%0d err=%0d n=%0d expected cyc=4 rnd=4 err=0 n=1", vcyc[0], vrnd[0], verr[0], vcnt[0]);
    end
    checks++;
    if ({vcyc[1], vrnd[1], verr[1], vcnt[1]} !== {32'd3, 32'd3, 32'd0, 32'd1}) begin
      failures++; $display("FAIL fallback: got cyc=%0d rnd=%0d err=%0d n=%0d expected cyc=3 rnd=3 err=0 n=1", vcyc[1], vrnd[1], verr[1], vcnt[1]);
    end
    checks++;
    if ({raw_a, raw_b} !== {8'h38, 8'h1C}) begin failures++; $display("FAIL reject_raw: got %h expected 381c", {raw_a, raw_b}); end
  endtask

  task automatic test_error();
    apply_reset();
    do_load(8'h47, 16'h1234);
    do_draw(8'd9, 8'd5, 3, 1'b0, 8'h00, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({vcyc[i], vrnd[i], verr[i], vcnt[i]} !== {32'd2, 32'd9, 32'd1, 32'd1}) begin
        failures++; $display("FAIL error_range dut%0d: got cyc=%0d rnd=%0d err=%0d n=%0d expected cyc=2 rnd=9 err=1 n=1", i, vcyc[i], vrnd[i], verr[i], vcnt[i]);
      end
    end
    checks++;
    if ({err_a, busy_a, rnd_a} !== {2'b00, 8'd9}) begin failures++; $display("FAIL error_after: got %h expected 009", {err_a, busy_a, rnd_a}); end
  endtask

  task automatic test_abort();
    int late = 0;
    apply_reset();
    do_load(8'h47, 16'h0047);
    lo = 8'd0; hi = 8'd4; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_draw: got %b expected 1", busy_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, err_a, raw_a} !== {3'b000, 8'h01}) begin
      failures++; $display("FAIL abort: got %h expected 001", {valid_a, busy_a, err_a, raw_a});
    end
    #2 rst_n = 1'b1;
    foreach (m[i]) m[i] = 32'd1;
    for (int c = 0; c < 20; c++) begin
      if (valid_a || valid_b || valid_c) late++;
      tick();
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL late_valid: got %0d expected 0", late); end
  endtask

  task automatic test_load_mid_draw();
    int k, r, e;
    logic [31:0] se;
    apply_reset();
    do_load(8'h47, 16'h1234);
    predict(m[2], 16, 16, 0, 4, 1, 32'h00A5, k, r, e, se);
    do_draw(8'd0, 8'd4, 1, 1'b1, 8'h01, 16'h00A5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({vcyc[i], vrnd[i], verr[i], vcnt[i]} !== {32'd3, 32'd1, 32'd0, 32'd1}) begin
        failures++; $display("FAIL load_mid dut%0d: got cyc=%0d rnd=%0d n=%0d expected cyc=3 rnd=1 n=1", i, vcyc[i], vrnd[i], vcnt[i]);
      end
    end
    checks++;
    if (raw_a !== 8'h02) begin failures++; $display("FAIL load_mid_raw: got %h expected 02", raw_a); end
    checks++;
    if ({vcyc[2], vrnd[2], verr[2], 32'(raw_c)} !== {k + 1, r, e, se}) begin
      failures++; $display("FAIL load_mid_c: got cyc=%0d rnd=%0d raw=%h expected cyc=%0d rnd=%0d raw=%h", vcyc[2], vrnd[2], raw_c, k + 1, r, se);
    end
  endtask

  task automatic test_random();
    int k [3], r [3], e [3];
    logic [31:0] se [3];
    logic [31:0] rawv [3];
    int li, hv;
    apply_reset();
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), 16'($urandom));
      en = 1'b1;
      repeat ($urandom_range(0, 5)) begin
        tick();
        foreach (m[i]) m[i] = mstep(m[i], wd[i]);
      end
      en = 1'b0;
      li = int'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0:       hv = li;
        1:       hv = (li + int'($urandom_range(0, 6)) > 255) ? 255 : li + int'($urandom_range(0, 6));
        default: hv = int'($urandom_range(0, 255));
      endcase
      for (int i = 0; i < 3; i++) predict(m[i], wd[i], mt[i], li, hv, 0, 32'd0, k[i], r[i], e[i], se[i]);
      do_draw(8'(li), 8'(hv), 1, 1'b0, 8'h00, 16'h0000);
      rawv[0] = 32'(raw_a); rawv[1] = 32'(raw_b); rawv[2] = 32'(raw_c);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({vcyc[i], vrnd[i], verr[i], vcnt[i], rawv[i]} !== {k[i] + 1, r[i], e[i], 32'd1, se[i]}) begin
          failures++;
          $display("FAIL rand[%0d] dut%0d lo=%0d hi=%0d: got cyc=%0d rnd=%0d err=%0d n=%0d raw=%h expected cyc=%0d rnd=%0d err=%0d n=1 raw=%h",
                   t, i, li, hv, vcyc[i], vrnd[i], verr[i], vcnt[i], rawv[i], k[i] + 1, r[i], e[i], se[i]);
        end
        checks++;
        if (verr[i] == 0 && (vrnd[i] < li || vrnd[i] > hv)) begin
          failures++; $display("FAIL rand_range[%0d] dut%0d: got %0d expected within %0d..%0d", t, i, vrnd[i], li, hv);
        end
        m[i] = se[i];
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period();
    test_load();
    test_immediate();
    test_reject();
    test_error();
    test_abort();
    test_load_mid_draw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
